sdp_burst_reader: RTL and testbench

//  Read-side sequencer for the sdp_1 simple-dual-port BRAM; drives its enb/addrb directly.

---
 rtl/sdp_pkg.sv | 18 +
 rtl/sdp_rd_skid_fifo.sv | 77 +++++++
 rtl/sdp_burst_reader.sv | 177 +++++++++++++++++
 tb/tb_sdp_burst_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_pkg.sv
// sdp_pkg
//  Shared types and helpers for the sdp_1 read-side burst sequencer.
//  state_t : sequencer FSM states (IDLE / ISSUE / DRAIN)
//  rd_lat  : BRAM read latency in cycles for a given output pipe depth
package sdp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One cycle for the BRAM array read plus one per output pipe register.
    function automatic int rd_lat(input int pipe_depth);
        return pipe_depth + 1;
    endfunction

endpackage

// File: rtl/sdp_rd_skid_fifo.sv
// sdp_rd_skid_fifo
//  Small register FIFO that absorbs BRAM read data while the stream
//  consumer applies backpressure. The head entry is presented
//  combinationally on dout; count is registered.
// Ports
//  clk, rst   clock and asynchronous active-high reset
//  push, din  write request and data (ignored when full without a pop)
//  pop        read request; removes the head entry when not empty
//  dout       head entry
//  count      current number of stored entries (0..DEPTH)
module sdp_rd_skid_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must never let a push hit a full FIFO
    // without a simultaneous pop.
    overflow_chk : assert property (@(posedge clk) disable iff (rst)
        !(push && full && !do_pop));

endmodule

// File: rtl/sdp_burst_reader.sv
// sdp_burst_reader
//  Read-side sequencer for the sdp_1 simple-dual-port BRAM. Accepts a burst
//  command (base, len), issues one read per cycle with address wrap, tracks
//  the fixed BRAM read latency with a tag shift register and delivers the
//  data as a valid/ready stream with a last flag. A credit limit keeps the
//  non-stallable BRAM read pipe from ever overrunning the skid FIFO.
// Ports
//  clk, rst                    clock, asynchronous active-high reset
//  cmd_valid/cmd_ready         burst command handshake (ready only in IDLE)
//  cmd_base, cmd_len           first address, beat count (0..DEPTH)
//  enb, addrb, doutb           BRAM read port
//  m_valid/m_ready             output stream handshake
//  m_data, m_last              stream beat and end-of-burst flag
//  busy                        high outside IDLE
//  done                        one-cycle pulse after the burst completes
module sdp_burst_reader
    import sdp_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int RD_LAT = rd_lat(PIPE_DEPTH);
    localparam int LW     = ADDR_WIDTH + 1;
    localparam int CW     = $clog2(SKID_DEPTH + 1);

    state_t                state;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] cur;
    logic [LW-1:0]         remaining;
    logic                  enb_last;
    logic [RD_LAT-1:0]     tag_valid;
    logic [RD_LAT-1:0]     tag_last;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  fifo_push;
    logic                  pop;
    logic                  cmd_fire;
    logic                  credit_ok;
    logic                  issue_go;
    logic                  issue_start;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [LW-1:0]         issue_rem;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);
    assign fifo_push = tag_valid[RD_LAT-1];
    assign m_valid   = (fifo_count != '0);
    assign m_data    = m_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
    assign m_last    = m_valid && fifo_dout[DATA_WIDTH];
    assign pop       = m_valid && m_ready;

    // Reads already issued plus beats parked in the FIFO may never exceed
    // the FIFO size, because returning BRAM data cannot be held back.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(SKID_DEPTH);

    // The first read is issued on the command handshake edge itself, so the
    // address source is the command in IDLE and the running counter later.
    always_comb begin
        issue_go    = 1'b0;
        issue_start = 1'b0;
        issue_addr  = cur;
        issue_rem   = remaining;
        state_n     = state;
        case (state)
            IDLE: begin
                if (cmd_fire && (cmd_len != '0)) begin
                    issue_start = 1'b1;
                    issue_addr  = cmd_base;
                    issue_rem   = cmd_len;
                    issue_go    = credit_ok;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                issue_go = credit_ok;
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        issue_last = issue_go && (issue_rem == LW'(1));
        if (issue_last) begin
            state_n = DRAIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            enb       <= 1'b0;
            enb_last  <= 1'b0;
            addrb     <= '0;
            cur       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_n;
            cmd_ready <= (state_n == IDLE);
            done      <= ((state == IDLE) && cmd_fire && (cmd_len == '0)) ||
                         ((state == DRAIN) && pop && m_last);
            enb       <= issue_go;
            enb_last  <= issue_last;
            if (issue_go) begin
                addrb     <= issue_addr;
                cur       <= issue_addr + ADDR_WIDTH'(1);
                remaining <= issue_rem - LW'(1);
            end else if (issue_start) begin
                cur       <= cmd_base;
                remaining <= cmd_len;
            end
        end
    end

    // Tag pipe: a read enabled in cycle C has its data on doutb in cycle
    // C+RD_LAT, which is exactly when its tag reaches the top bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid <= (tag_valid << 1) | RD_LAT'(enb);
            tag_last  <= (tag_last << 1) | RD_LAT'(enb && enb_last);
        end
    end

    // inflight counts reads whose data has not yet entered the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue_go, fifo_push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    sdp_rd_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({tag_last[RD_LAT-1], doutb}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_sdp_burst_reader.sv
// tb_sdp_burst_reader
//  Directed bench for sdp_burst_reader with a behavioural sdp_1 read port
//  (PIPE_DEPTH=1, ram[i]=i). Expected stream beats are queued when a burst
//  is issued; an independent monitor pops and compares on every handshake.
module tb_sdp_burst_reader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int PD = 1;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    int cmp_cnt    = 0;
    int fail_cnt   = 0;
    int issued_cnt = 0;
    int popped_cnt = 0;

    logic [DW:0]   exp_q [$];
    logic [AW-1:0] t2_exp [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};

    sdp_burst_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PIPE_DEPTH (PD),
        .SKID_DEPTH (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural sdp_1 read side: array read register plus one output pipe stage.
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] bram_q1;
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = DW'(i);
    end
    always @(posedge clk) begin
        if (enb) bram_q1 <= ram[addrb];
        doutb <= bram_q1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every stream handshake must match the queue head.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            cmp_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("[TB] FAIL stream_extra_beat: got data 0x%0h last %0b, expected no beat", m_data, m_last);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({m_last, m_data} !== e) begin
                    fail_cnt++;
                    $display("[TB] FAIL stream_beat: got data 0x%0h last %0b, expected data 0x%0h last %0b",
                             m_data, m_last, e[DW-1:0], e[DW]);
                end
            end
        end
    end

    // Running counts of issued reads and delivered beats.
    always @(negedge clk) begin
        if (!rst && enb) issued_cnt++;
        if (!rst && m_valid && m_ready) popped_cnt++;
    end

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len, input bit expect_data);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        if (expect_data) begin
            for (int i = 0; i < int'(len); i++) begin
                logic [AW-1:0] a;
                a = base + AW'(i);
                exp_q.push_back({(i == int'(len) - 1), DW'(a)});
            end
        end
        cmd_base  = base;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 64'(seen), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit saw_enb;
        bit saw_valid;
        bit seen_done;
        int s_iss;
        int s_pop;
        logic [AW-1:0] seen_addr [$];

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        m_ready   = 1'b1;

        #12;
        checkOutput("reset_outputs",
                    64'({cmd_ready, enb, addrb, m_valid, m_data, m_last, busy, done}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("cmd_ready_at_release", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        checkOutput("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Test 1: base 0, len 4, consumer always ready.
        $display("[TB] test 1: base=0 len=4");
        applyStimulus(10'd0, 11'd4, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t1_enb_k%0d", k), 64'(enb), 64'(k <= 4));
            if (k <= 4) checkOutput($sformatf("t1_addrb_k%0d", k), 64'(addrb), 64'(k - 1));
            checkOutput($sformatf("t1_m_valid_k%0d", k), 64'(m_valid), 64'(k >= 4 && k <= 7));
            checkOutput($sformatf("t1_done_k%0d", k), 64'(done), 64'(k == 8));
            checkOutput($sformatf("t1_busy_k%0d", k), 64'(busy), 64'(k <= 7));
        end
        @(posedge clk); #1;

        // Test 2: wrap across the top of the address space.
        $display("[TB] test 2: base=1022 len=4");
        seen_addr.delete();
        seen_done = 1'b0;
        applyStimulus(10'd1022, 11'd4, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (enb) seen_addr.push_back(addrb);
            if (done) seen_done = 1'b1;
        end
        checkOutput("t2_issue_count", 64'(seen_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen_addr.size())
                checkOutput($sformatf("t2_addrb_%0d", i), 64'(seen_addr[i]), 64'(t2_exp[i]));
        end
        checkOutput("t2_done", 64'(seen_done), 64'd1);
        @(posedge clk); #1;

        // Test 3: backpressure mid-burst must stop issue at the credit limit.
        $display("[TB] test 3: len=16 with 10-cycle stall");
        s_iss = issued_cnt;
        s_pop = popped_cnt;
        applyStimulus(10'd64, 11'd16, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        m_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        checkOutput("t3_enb_stalled", 64'(enb), 64'd0);
        checkOutput("t3_outstanding", 64'((issued_cnt - s_iss) - (popped_cnt - s_pop)), 64'(SD));
        m_ready = 1'b1;
        waitDone(200, "t3_done");

        // Test 4: empty burst.
        $display("[TB] test 4: len=0");
        saw_enb   = 1'b0;
        saw_valid = 1'b0;
        applyStimulus(10'd5, 11'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) checkOutput("t4_done_pulse", 64'(done), 64'd1);
            if (k == 1) checkOutput("t4_cmd_ready", 64'(cmd_ready), 64'd1);
            if (k == 2) checkOutput("t4_done_clear", 64'(done), 64'd0);
            saw_enb   |= enb;
            saw_valid |= m_valid;
        end
        checkOutput("t4_no_enb", 64'(saw_enb), 64'd0);
        checkOutput("t4_no_m_valid", 64'(saw_valid), 64'd0);
        @(posedge clk); #1;

        // Test 5: asynchronous reset in the middle of a burst.
        $display("[TB] test 5: reset during len=8 burst");
        applyStimulus(10'd200, 11'd8, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_async_reset_outputs",
                    64'({cmd_ready, enb, addrb, m_valid, m_data, m_last, busy, done}), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            saw_valid |= m_valid;
        end
        checkOutput("t5_no_stray_valid", 64'(saw_valid), 64'd0);
        @(posedge clk); #1;
        applyStimulus(10'd100, 11'd2, 1'b1);
        waitDone(50, "t5_done");

        // Test 6: full-depth burst with random backpressure.
        $display("[TB] test 6: len=1024 random m_ready");
        applyStimulus(10'd0, 11'd1024, 1'b1);
        seen_done = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("t6_done", 64'(seen_done), 64'd1);
        m_ready = 1'b1;

        repeat (5) begin @(posedge clk); #1; end
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
